// File: rtl/restoring_divider_if.sv
// Purpose  : START/DONE handshake bundle between a controller and restoring_divider.
// Latency  : n/a (signal bundle only).
// Backpres.: START is ignored by the divider while BUSY is high.
// Ports    : START, DIVIDEND, DIVISOR  (controller -> divider)
//            BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO  (divider -> controller)
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIV_ZERO;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO
  );
endinterface

// File: rtl/restoring_divider.sv
// Purpose  : Unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency  : DONE in the cycle after edge k+WIDTH (k+1 for a zero divisor).
// Backpres.: START accepted only while idle; START while BUSY is ignored.
// Ports    : CLK, RST_N (async active-low); bus = restoring_divider_if.slave
//            (START/DIVIDEND/DIVISOR in, BUSY/DONE/QUOTIENT/REMAINDER/DIV_ZERO out).
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  restoring_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_dvd;        // dividend, shifted left one bit per iteration
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;        // partial remainder
  logic [WIDTH-2:0] r_quo;        // quotient bits gathered so far
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic             r_done;

  logic             w_accept;
  logic             w_busy;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_accept = (r_state == S_IDLE) && bus.START;

  // One extra bit keeps the borrow exact even for a divisor of all ones.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_borrow  = w_trial[WIDTH];
  // On borrow the shifted value is below the divisor, so it fits in WIDTH bits.
  assign w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo, ~w_borrow};

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_next = (bus.DIVISOR == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      S_ZERO:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    if (r_state != S_IDLE) begin
      w_busy = 1'b1;
    end
  end

  // Datapath and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd <= bus.DIVIDEND;
            r_dvs <= bus.DIVISOR;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CNT_W'(WIDTH - 1);
          end
        end
        S_RUN: begin
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt[WIDTH-2:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quotient  <= w_quo_nxt;
            r_remainder <= w_rem_nxt;
            r_div_zero  <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        S_ZERO: begin
          r_quotient  <= '1;
          r_remainder <= r_dvd;
          r_div_zero  <= 1'b1;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY      = w_busy;
  assign bus.DONE      = r_done;
  assign bus.QUOTIENT  = r_quotient;
  assign bus.REMAINDER = r_remainder;
  assign bus.DIV_ZERO  = r_div_zero;
endmodule

// File: tb/tb_restoring_divider.sv
// Purpose  : Self-checking bench for restoring_divider (WIDTH=8).
// Latency  : n/a.
// Backpres.: n/a.
// Ports    : none (top-level bench).
module tb_restoring_divider;
  localparam int W = 8;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_z;

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer division, all-ones/dividend on zero.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = W'(int'(a) / int'(b)); r = W'(int'(a) % int'(b)); z = 1'b0;
    end
  endtask

  // Starts a division and waits for DONE. inj>0 pulses START with 50/5 so that
  // it is sampled at edge k+inj. Returns cycles from acceptance to DONE and
  // whether BUSY/held outputs behaved while waiting.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inj,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output bit hold_ok);
    @(negedge CLK);
    bus.START = 1'b1; bus.DIVIDEND = a; bus.DIVISOR = b;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.DIVIDEND = W'($urandom); bus.DIVISOR = W'($urandom);
    lat = 0;
    hold_ok = 1'b1;
    while (!bus.DONE && lat < 20) begin
      if (!bus.BUSY || bus.QUOTIENT != prev_q || bus.REMAINDER != prev_r ||
          bus.DIV_ZERO != prev_z) hold_ok = 1'b0;
      if (inj > 0 && lat + 1 == inj) begin
        bus.START = 1'b1; bus.DIVIDEND = 8'd50; bus.DIVISOR = 8'd5;
      end else begin
        bus.START = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    bus.START = 1'b0;
    if (bus.BUSY) hold_ok = 1'b0;
    q = bus.QUOTIENT; r = bus.REMAINDER; z = bus.DIV_ZERO;
    prev_q = q; prev_r = r; prev_z = z;
  endtask

  initial begin
    int           lat;
    logic [W-1:0] q, r, eq, er;
    logic         z, ez;
    bit           hold_ok;
    bit           seen;

    checks = 0; errors = 0;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    bus.START = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, W};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, W};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, W};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, W};
    vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, W};
    vecs[5] = '{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 1};
    vecs[6] = '{8'd10,  8'd3,   8'd3,   8'd1,  1'b0, W};

    // Reset state
    RST_N = 1'b0;
    #12;
    check("reset_busy", bus.BUSY, 0);
    check("reset_done", bus.DONE, 0);
    check("reset_q", bus.QUOTIENT, 0);
    check("reset_r", bus.REMAINDER, 0);
    check("reset_z", bus.DIV_ZERO, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_div(vecs[i].a, vecs[i].b, 0, lat, q, r, z, hold_ok);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_z", i), z, vecs[i].z);
      check($sformatf("vec%0d_busy_hold", i), hold_ok, 1);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), bus.DONE, 0);
    end

    // START pulse while busy must be ignored
    do_div(8'd200, 8'd13, 3, lat, q, r, z, hold_ok);
    check("ign_lat", lat, W);
    check("ign_q", q, 15);
    check("ign_r", r, 5);
    check("ign_busy_hold", hold_ok, 1);
    @(negedge CLK);
    check("ign_after_busy", bus.BUSY, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge CLK);
    bus.START = 1'b1; bus.DIVIDEND = 8'd200; bus.DIVISOR = 8'd7;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_busy", bus.BUSY, 0);
    check("mid_rst_done", bus.DONE, 0);
    check("mid_rst_q", bus.QUOTIENT, 0);
    check("mid_rst_r", bus.REMAINDER, 0);
    check("mid_rst_z", bus.DIV_ZERO, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check("mid_rst_no_done", seen, 0);
    do_div(8'd9, 8'd4, 0, lat, q, r, z, hold_ok);
    check("post_rst_q", q, 2);
    check("post_rst_r", r, 1);
    check("post_rst_lat", lat, W);

    // Back-to-back: START held high through DONE
    @(negedge CLK);
    bus.START = 1'b1; bus.DIVIDEND = 8'd100; bus.DIVISOR = 8'd7;
    @(negedge CLK);
    bus.DIVIDEND = 8'd63; bus.DIVISOR = 8'd8;
    lat = 0;
    while (!bus.DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("b2b_first_lat", lat, W);
    check("b2b_first_q", bus.QUOTIENT, 14);
    check("b2b_first_r", bus.REMAINDER, 2);
    @(negedge CLK);
    bus.START = 1'b0;
    lat = 1;
    while (!bus.DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("b2b_second_lat", lat, W + 1);
    check("b2b_second_q", bus.QUOTIENT, 7);
    check("b2b_second_r", bus.REMAINDER, 7);
    prev_q = bus.QUOTIENT; prev_r = bus.REMAINDER; prev_z = bus.DIV_ZERO;

    // Random sweep against the reference and the division invariants
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      ref_div(a, b, eq, er, ez);
      do_div(a, b, 0, lat, q, r, z, hold_ok);
      check($sformatf("rnd%0d_q %0d/%0d", n, a, b), q, eq);
      check($sformatf("rnd%0d_r %0d/%0d", n, a, b), r, er);
      check($sformatf("rnd%0d_z", n), z, ez);
      check($sformatf("rnd%0d_lat", n), lat, (b == 0) ? 1 : W);
      if (b != 0) begin
        check($sformatf("rnd%0d_inv_eq", n), int'(q) * int'(b) + int'(r), int'(a));
        check($sformatf("rnd%0d_inv_lt", n), (r < b), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
